// File: rtl/brightness_keys.sv
// Two-key brightness front end: synchronizes and debounces the active-low
// up/down keys, then issues one-clock inc/dec strobes with hold-to-repeat.
// Strobes that the brightness stage would ignore at level 0 or 15 are dropped,
// while the repeat timing carries on as if they had been sent.
//
// Strobe handshake: inc/dec are single-cycle, valid-only strobes with no ready.
// The stage consumes each strobe on the next clock edge.
module brightness_keys #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_up_n,
    input  logic       key_dn_n,
    input  logic [3:0] level_in,
    output logic       inc,
    output logic       dec,
    output logic       held
);

    localparam int DBW  = $clog2(DEBOUNCE_CYCLES);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(TMAX);

    localparam logic [DBW-1:0] DB_LAST     = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]  DELAY_LOAD  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0]  PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2,
        LOCK = 2'd3
    } state_t;

    logic [1:0]     up_sync;
    logic [1:0]     dn_sync;
    logic           up_s;
    logic           dn_s;
    logic [DBW-1:0] up_cnt;
    logic [DBW-1:0] dn_cnt;
    logic           up_db;
    logic           dn_db;

    // Current FSM state; named so checkers can bind to it directly.
    state_t         state;
    state_t         state_next;
    logic           dir_up;
    logic           dir_next;
    logic [TW-1:0]  timer;
    logic [TW-1:0]  timer_next;
    logic           fire;
    logic           inc_next;
    logic           dec_next;
    logic           key_mine;
    logic           key_other;

    // Two-flop synchronizers; reset to the released (high) pin level.
    always_ff @(posedge clk) begin
        if (rst) begin
            up_sync <= 2'b11;
            dn_sync <= 2'b11;
        end else begin
            up_sync <= {up_sync[0], key_up_n};
            dn_sync <= {dn_sync[0], key_dn_n};
        end
    end

    assign up_s = ~up_sync[1];
    assign dn_s = ~dn_sync[1];

    // Up-key debounce: accept a change only after DEBOUNCE_CYCLES stable samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            up_cnt <= '0;
            up_db  <= 1'b0;
        end else if (up_s == up_db) begin
            up_cnt <= '0;
        end else if (up_cnt == DB_LAST) begin
            up_db  <= up_s;
            up_cnt <= '0;
        end else begin
            up_cnt <= up_cnt + DBW'(1);
        end
    end

    // Down-key debounce, identical to the up key.
    always_ff @(posedge clk) begin
        if (rst) begin
            dn_cnt <= '0;
            dn_db  <= 1'b0;
        end else if (dn_s == dn_db) begin
            dn_cnt <= '0;
        end else if (dn_cnt == DB_LAST) begin
            dn_db  <= dn_s;
            dn_cnt <= '0;
        end else begin
            dn_cnt <= dn_cnt + DBW'(1);
        end
    end

    // Next-state logic: press/hold/repeat/lock sequencing plus limit suppression.
    always_comb begin
        state_next = state;
        dir_next   = dir_up;
        timer_next = timer;
        fire       = 1'b0;
        inc_next   = 1'b0;
        dec_next   = 1'b0;
        key_mine   = dir_up ? up_db : dn_db;
        key_other  = dir_up ? dn_db : up_db;

        case (state)
            IDLE: begin
                if (up_db && dn_db) begin
                    state_next = LOCK;
                end else if (up_db || dn_db) begin
                    dir_next   = up_db;
                    fire       = 1'b1;
                    timer_next = DELAY_LOAD;
                    state_next = HOLD;
                end
            end
            HOLD, RPT: begin
                if (!key_mine) begin
                    state_next = IDLE;
                end else if (key_other) begin
                    state_next = LOCK;
                end else if (timer == '0) begin
                    fire       = 1'b1;
                    timer_next = PERIOD_LOAD;
                    state_next = RPT;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            LOCK: begin
                if (!up_db && !dn_db) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A due pulse the stage would ignore is dropped; sequencing is unchanged.
        if (fire) begin
            if (dir_next && (level_in != 4'd15)) begin
                inc_next = 1'b1;
            end
            if (!dir_next && (level_in != 4'd0)) begin
                dec_next = 1'b1;
            end
        end
    end

    // State, timer and registered outputs; held trails the state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            dir_up <= 1'b0;
            timer  <= '0;
            inc    <= 1'b0;
            dec    <= 1'b0;
            held   <= 1'b0;
        end else begin
            state  <= state_next;
            dir_up <= dir_next;
            timer  <= timer_next;
            inc    <= inc_next;
            dec    <= dec_next;
            held   <= (state == HOLD) || (state == RPT);
        end
    end

endmodule

// File: tb/tb_brightness_keys.sv
// Bench for brightness_keys: drives key presses, models the brightness stage,
// and predicts strobe times from press/release edges and the repeat rules.
module tb_brightness_keys;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 5;
    localparam int BIG = 32'h3fff_ffff;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_up_n = 1'b1;
    logic       key_dn_n = 1'b1;
    logic [3:0] level = 4'd8;
    logic       inc;
    logic       dec;
    logic       held;

    logic       load_level = 1'b0;
    logic [3:0] load_val = 4'd0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int exp_level = 8;
    logic [31:0] exp_q[$];

    int got_inc[$];
    int got_dec[$];
    int held_cnt = 0;
    int both_cnt = 0;

    brightness_keys #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_up_n(key_up_n),
        .key_dn_n(key_dn_n),
        .level_in(level),
        .inc(inc),
        .dec(dec),
        .held(held)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // brightness stage model: level follows strobes one edge later, clamped
    always @(posedge clk) begin
        if (load_level) level <= load_val;
        else if (inc && level != 4'd15) level <= level + 4'd1;
        else if (dec && level != 4'd0) level <= level - 4'd1;
    end

    // monitor on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (inc) got_inc.push_back(cyc);
        if (dec) got_dec.push_back(cyc);
        if (held) held_cnt = held_cnt + 1;
        if (inc && dec) both_cnt = both_cnt + 1;
    end

    // watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // reference: a press first sampled low at edge k and first sampled high at
    // edge r yields due pulses at k+DB+2, then +RD, then every +RP, as long as
    // the due edge is no later than release recognition (r+DB+1) and before cut.
    task automatic model_press(input bit up, input int k, input int r, input int cut);
        int t;
        bit first;
        exp_q.delete();
        t = k + DB + 2;
        first = 1'b1;
        while (t <= r + DB + 1 && t < cut) begin
            if (up) begin
                if (exp_level != 15) begin
                    exp_q.push_back(t);
                    exp_level = exp_level + 1;
                end
            end else begin
                if (exp_level != 0) begin
                    exp_q.push_back(t);
                    exp_level = exp_level - 1;
                end
            end
            t = t + (first ? RD : RP);
            first = 1'b0;
        end
    endtask

    task automatic set_level(input int v);
        @(negedge clk);
        load_level = 1'b1;
        load_val = 4'(v);
        @(negedge clk);
        load_level = 1'b0;
        exp_level = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load_level = 1'b1;
        load_val = 4'd8;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({inc, dec, held} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: inc/dec/held=%b required 000", {inc, dec, held});
        end
        rst = 1'b0;
        load_level = 1'b0;
        exp_level = 8;
        repeat (10) @(negedge clk);
        n_checks++;
        if (got_inc.size() + got_dec.size() + held_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_idle: activity=%0d required 0", got_inc.size() + got_dec.size() + held_cnt);
        end
    endtask

    // one key held for n sampled cycles, then released and allowed to settle
    task automatic test_press(input bit up, input int n, input int start_level, input string name);
        int bi, bd, bh, bb, k, r;
        int got[$];
        int other;
        if (start_level >= 0) set_level(start_level);
        bi = got_inc.size();
        bd = got_dec.size();
        bh = held_cnt;
        bb = both_cnt;
        @(negedge clk);
        if (up) key_up_n = 1'b0; else key_dn_n = 1'b0;
        k = cyc + 1;
        repeat (n) @(negedge clk);
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
        r = cyc + 1;
        repeat (14) @(negedge clk);
        model_press(up, k, r, BIG);
        if (up) begin
            for (int i = bi; i < got_inc.size(); i++) got.push_back(got_inc[i]);
            other = got_dec.size() - bd;
        end else begin
            for (int i = bd; i < got_dec.size(); i++) got.push_back(got_dec[i]);
            other = got_inc.size() - bi;
        end
        n_checks++;
        if (got.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: pulses=%0d required %0d", name, got.size(), exp_q.size());
        end
        for (int j = 0; j < exp_q.size(); j++) begin
            if (j < got.size()) begin
                n_checks++;
                if (got[j] !== int'(exp_q[j])) begin
                    n_fail++;
                    $display("FAIL %s_time%0d: edge=%0d required %0d (press edge %0d)", name, j, got[j], exp_q[j], k);
                end
            end
        end
        n_checks++;
        if (other !== 0) begin
            n_fail++;
            $display("FAIL %s_other_key: pulses=%0d required 0", name, other);
        end
        n_checks++;
        if (held_cnt - bh !== n) begin
            n_fail++;
            $display("FAIL %s_held: cycles=%0d required %0d", name, held_cnt - bh, n);
        end
        n_checks++;
        if (both_cnt - bb !== 0) begin
            n_fail++;
            $display("FAIL %s_exclusive: overlaps=%0d required 0", name, both_cnt - bb);
        end
        n_checks++;
        if (int'(level) !== exp_level) begin
            n_fail++;
            $display("FAIL %s_level: level=%0d required %0d", name, level, exp_level);
        end
    endtask

    task automatic test_glitch();
        int bi, bd, bh;
        bi = got_inc.size();
        bd = got_dec.size();
        bh = held_cnt;
        @(negedge clk);
        key_dn_n = 1'b0;
        repeat (3) @(negedge clk);
        key_dn_n = 1'b1;
        repeat (14) @(negedge clk);
        n_checks++;
        if ((got_inc.size() - bi) + (got_dec.size() - bd) !== 0) begin
            n_fail++;
            $display("FAIL glitch_pulses: pulses=%0d required 0", (got_inc.size() - bi) + (got_dec.size() - bd));
        end
        n_checks++;
        if (held_cnt - bh !== 0) begin
            n_fail++;
            $display("FAIL glitch_held: cycles=%0d required 0", held_cnt - bh);
        end
    endtask

    task automatic test_both_keys();
        int bi, bd, k;
        set_level(8);
        bi = got_inc.size();
        bd = got_dec.size();
        @(negedge clk);
        key_up_n = 1'b0;
        k = cyc + 1;
        repeat (10) @(negedge clk);
        key_dn_n = 1'b0;
        repeat (20) @(negedge clk);
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
        repeat (14) @(negedge clk);
        exp_level = 9;
        n_checks++;
        if (got_inc.size() - bi !== 1) begin
            n_fail++;
            $display("FAIL both_inc_count: pulses=%0d required 1", got_inc.size() - bi);
        end else begin
            n_checks++;
            if (got_inc[bi] !== k + DB + 2) begin
                n_fail++;
                $display("FAIL both_inc_time: edge=%0d required %0d", got_inc[bi], k + DB + 2);
            end
        end
        n_checks++;
        if (got_dec.size() - bd !== 0) begin
            n_fail++;
            $display("FAIL both_dec_count: pulses=%0d required 0", got_dec.size() - bd);
        end
        n_checks++;
        if (int'(level) !== exp_level) begin
            n_fail++;
            $display("FAIL both_level: level=%0d required %0d", level, exp_level);
        end
    endtask

    task automatic test_reset_mid_repeat();
        int bi, k0, k, r, rr;
        int got[$];
        set_level(3);
        bi = got_inc.size();
        @(negedge clk);
        key_up_n = 1'b0;
        k0 = cyc + 1;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        rr = cyc + 1;
        @(negedge clk);
        n_checks++;
        if ({inc, held} !== 2'b00) begin
            n_fail++;
            $display("FAIL midreset_outputs: inc/held=%b required 00", {inc, held});
        end
        rst = 1'b0;
        model_press(1'b1, k0, BIG, rr);
        for (int i = bi; i < got_inc.size(); i++) got.push_back(got_inc[i]);
        n_checks++;
        if (got.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL midreset_pre_count: pulses=%0d required %0d", got.size(), exp_q.size());
        end
        bi = got_inc.size();
        k = rr + 1;
        repeat (25) @(negedge clk);
        key_up_n = 1'b1;
        r = cyc + 1;
        repeat (14) @(negedge clk);
        model_press(1'b1, k, r, BIG);
        got.delete();
        for (int i = bi; i < got_inc.size(); i++) got.push_back(got_inc[i]);
        n_checks++;
        if (got.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL midreset_post_count: pulses=%0d required %0d", got.size(), exp_q.size());
        end
        for (int j = 0; j < exp_q.size(); j++) begin
            if (j < got.size()) begin
                n_checks++;
                if (got[j] !== int'(exp_q[j])) begin
                    n_fail++;
                    $display("FAIL midreset_post_time%0d: edge=%0d required %0d", j, got[j], exp_q[j]);
                end
            end
        end
        n_checks++;
        if (int'(level) !== exp_level) begin
            n_fail++;
            $display("FAIL midreset_level: level=%0d required %0d", level, exp_level);
        end
    endtask

    initial begin
        test_reset();
        test_press(1'b1, 10, 8, "single_tap");
        test_glitch();
        test_press(1'b1, 60, 8, "hold_repeat");
        test_press(1'b0, 40, 0, "lower_limit");
        test_both_keys();
        test_press(1'b1, 6, -1, "tap_after_lock");
        test_reset_mid_repeat();
        for (int it = 0; it < 8; it++) begin
            test_press(1'($urandom_range(0, 1)), $urandom_range(5, 45),
                       (it % 2 == 0) ? int'($urandom_range(0, 15)) : -1, "random");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
